rr_write_arbiter: RTL and testbench

Parametrised round-robin arbiter that multiplexes N writer modules onto a single FIFO write port. It replaces the fixed-priority two-writer arbiter with fair round-robin or legacy fixed-priority selection, FIFO-full backpressure and a registered grant ID. It keeps the existing writer handshake: `o_busy` low means granted, and the writer holds its data while busy. It sits between the writer instances and the shared FIFO `we`/`wdata`/`full` port.

---
 rtl/arbiter_pkg.sv | 26 ++
 rtl/rr_pick.sv | 41 ++++
 rtl/rr_write_arbiter.sv | 123 ++++++++++++
 tb/tb_rr_write_arbiter.sv | 243 ++++++++++++++++++++++++
 4 files changed

// File: rtl/arbiter_pkg.sv
`default_nettype none
// ============================================================================
// Module      : arbiter_pkg
// Description : Shared types and constants for the FIFO write arbiter:
//               FSM state encoding, priority-mode selectors and a helper
//               that sizes the writer index.
// Revision    : 1.0 - initial release
// ============================================================================
package arbiter_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        GRANT = 2'd1,
        WRITE = 2'd2
    } arb_state_e;

    localparam int PRIORITY_RR    = 0;
    localparam int PRIORITY_FIXED = 1;

    // Index width for n writers; a single writer still needs one bit.
    function automatic int id_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage
`default_nettype wire

// File: rtl/rr_pick.sv
`default_nettype none
// ============================================================================
// Module      : rr_pick
// Description : Combinational winner selection. Round-robin mode returns the
//               first set request at or above i_ptr (wrapping); fixed mode
//               returns the highest set request.
// Revision    : 1.0 - initial release
// ============================================================================
module rr_pick #(
    parameter int NUM_WRITERS = 4,
    parameter int ID_W        = 2
) (
    input  logic [NUM_WRITERS-1:0] i_req,
    input  logic [ID_W-1:0]        i_ptr,
    input  logic                   i_fixed,
    output logic                   o_found,
    output logic [ID_W-1:0]        o_idx
);

    int w_cand;

    // Scan in reverse so the last assignment is the highest-priority hit.
    always_comb begin
        o_found = |i_req;
        o_idx   = '0;
        w_cand  = 0;
        if (i_fixed) begin
            for (int j = 0; j < NUM_WRITERS; j++) begin
                if (i_req[j]) o_idx = ID_W'(j);
            end
        end else begin
            for (int k = NUM_WRITERS - 1; k >= 0; k--) begin
                w_cand = int'(i_ptr) + k;
                if (w_cand >= NUM_WRITERS) w_cand = w_cand - NUM_WRITERS;
                if (i_req[w_cand]) o_idx = ID_W'(w_cand);
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/rr_write_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : rr_write_arbiter
// Description : Multiplexes NUM_WRITERS writers onto one FIFO write port with
//               round-robin or fixed (highest index) priority. Grant is an
//               active-low busy bit; each accepted request yields a single
//               o_we pulse two cycles after the decision.
// Revision    : 1.0 - initial release
// ============================================================================
module rr_write_arbiter
    import arbiter_pkg::*;
#(
    parameter  int NUM_WRITERS   = 4,
    parameter  int DATA_W        = 8,
    parameter  int PRIORITY_MODE = 0,
    localparam int ID_W          = id_width(NUM_WRITERS)
) (
    input  logic                          i_clk,
    input  logic                          i_reset,
    input  logic [NUM_WRITERS*DATA_W-1:0] i_data,
    input  logic [NUM_WRITERS-1:0]        i_req,
    input  logic                          i_full,
    output logic [NUM_WRITERS-1:0]        o_busy,
    output logic [DATA_W-1:0]             o_data,
    output logic                          o_we,
    output logic [ID_W-1:0]               o_grant_id
);

    localparam logic c_fixed_mode = (PRIORITY_MODE == PRIORITY_FIXED);

    arb_state_e              r_state, w_state_nxt;
    logic [NUM_WRITERS-1:0]  r_busy, w_busy_nxt;
    logic                    r_we, w_we_nxt;
    logic [DATA_W-1:0]       r_data, w_data_nxt;
    logic [ID_W-1:0]         r_grant_id, w_grant_id_nxt;
    logic [ID_W-1:0]         r_ptr, w_ptr_nxt;

    logic                    w_found;
    logic [ID_W-1:0]         w_pick;
    logic [ID_W-1:0]         w_ptr_inc;
    logic [DATA_W-1:0]       w_sel_data;

    rr_pick #(
        .NUM_WRITERS (NUM_WRITERS),
        .ID_W        (ID_W)
    ) u_pick (
        .i_req   (i_req),
        .i_ptr   (r_ptr),
        .i_fixed (c_fixed_mode),
        .o_found (w_found),
        .o_idx   (w_pick)
    );

    // Pointer moves just past the writer that held the grant.
    assign w_ptr_inc  = (r_grant_id == ID_W'(NUM_WRITERS - 1)) ? '0 : r_grant_id + 1'b1;
    assign w_sel_data = i_data[int'(r_grant_id)*DATA_W +: DATA_W];

    // Next-state and next-output decode; every output is registered below.
    always_comb begin
        w_state_nxt    = r_state;
        w_busy_nxt     = r_busy;
        w_we_nxt       = 1'b0;
        w_data_nxt     = r_data;
        w_grant_id_nxt = r_grant_id;
        w_ptr_nxt      = r_ptr;
        case (r_state)
            IDLE: begin
                w_busy_nxt = '1;
                // Full is only checked here: a decision reserves one slot.
                if (w_found && !i_full) begin
                    w_busy_nxt[w_pick] = 1'b0;
                    w_grant_id_nxt     = w_pick;
                    w_state_nxt        = GRANT;
                end
            end
            GRANT: begin
                w_busy_nxt = '1;
                if (i_req[r_grant_id]) begin
                    w_data_nxt  = w_sel_data;
                    w_we_nxt    = 1'b1;
                    w_state_nxt = WRITE;
                end else begin
                    w_state_nxt = IDLE;
                end
                // A withdrawn request still consumes its turn.
                if (!c_fixed_mode) w_ptr_nxt = w_ptr_inc;
            end
            WRITE: begin
                w_state_nxt = IDLE;
            end
            default: begin
                w_busy_nxt  = '1;
                w_state_nxt = IDLE;
            end
        endcase
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_state    <= IDLE;
            r_busy     <= '1;
            r_we       <= 1'b0;
            r_data     <= '0;
            r_grant_id <= '0;
            r_ptr      <= '0;
        end else begin
            r_state    <= w_state_nxt;
            r_busy     <= w_busy_nxt;
            r_we       <= w_we_nxt;
            r_data     <= w_data_nxt;
            r_grant_id <= w_grant_id_nxt;
            r_ptr      <= w_ptr_nxt;
        end
    end

    assign o_busy     = r_busy;
    assign o_we       = r_we;
    assign o_data     = r_data;
    assign o_grant_id = r_grant_id;

endmodule
`default_nettype wire

// File: tb/tb_rr_write_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_rr_write_arbiter
// Description : Self-checking bench for rr_write_arbiter (3 writers, 8-bit
//               data). A round-robin and a fixed-priority instance share the
//               stimulus; expected writes are queued and popped on o_we.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_rr_write_arbiter;

    localparam int N  = 3;
    localparam int DW = 8;

    typedef struct {
        logic [DW-1:0] data;
        logic [1:0]    id;
    } exp_t;

    logic            clk = 1'b0;
    logic            rst;
    logic [N*DW-1:0] data;
    logic [N-1:0]    req;
    logic            full;

    logic [N-1:0]    busy,  fbusy;
    logic [DW-1:0]   wdata, fwdata;
    logic            we,    fwe;
    logic [1:0]      gid,   fgid;

    int   n_tests = 0;
    int   n_fail  = 0;
    int   wr_cnt  = 0;
    logic mon_en  = 1'b0;
    logic fix_en  = 1'b0;

    exp_t q_rr[$];
    exp_t q_fix[$];

    always #5 clk = ~clk;

    rr_write_arbiter #(
        .NUM_WRITERS   (N),
        .DATA_W        (DW),
        .PRIORITY_MODE (0)
    ) dut (
        .i_clk      (clk),
        .i_reset    (rst),
        .i_data     (data),
        .i_req      (req),
        .i_full     (full),
        .o_busy     (busy),
        .o_data     (wdata),
        .o_we       (we),
        .o_grant_id (gid)
    );

    rr_write_arbiter #(
        .NUM_WRITERS   (N),
        .DATA_W        (DW),
        .PRIORITY_MODE (1)
    ) dut_fixed (
        .i_clk      (clk),
        .i_reset    (rst),
        .i_data     (data),
        .i_req      (req),
        .i_full     (full),
        .o_busy     (fbusy),
        .o_data     (fwdata),
        .o_we       (fwe),
        .o_grant_id (fgid)
    );

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    function automatic exp_t mk(input logic [DW-1:0] d, input logic [1:0] i);
        exp_t e;
        e.data = d;
        e.id   = i;
        return e;
    endfunction

    // Round-robin instance: pop expected write on every o_we, watch grant one-hot.
    always @(negedge clk) begin
        if (mon_en) begin
            if (we === 1'b1) begin
                if (q_rr.size() == 0) begin
                    check_val("rr_unexpected_we", 32'd1, 32'd0);
                end else begin
                    exp_t e;
                    e = q_rr.pop_front();
                    check_val("rr_wdata", 32'(wdata), 32'(e.data));
                    check_val("rr_wid", 32'(gid), 32'(e.id));
                end
                wr_cnt++;
            end
            check_val("busy_onehot", 32'($countones(~busy) <= 1), 32'd1);
        end
    end

    // Fixed-priority instance: only scored during the shared round-robin run.
    always @(negedge clk) begin
        if (fix_en && fwe === 1'b1) begin
            if (q_fix.size() == 0) begin
                check_val("fix_unexpected_we", 32'd1, 32'd0);
            end else begin
                exp_t e;
                e = q_fix.pop_front();
                check_val("fix_wdata", 32'(fwdata), 32'(e.data));
                check_val("fix_wid", 32'(fgid), 32'(e.id));
            end
        end
    end

    initial begin
        rst  = 1'b1;
        req  = 3'b111;
        full = 1'b0;
        data = {8'h30, 8'h20, 8'h10};

        // Reset held two cycles with all writers requesting.
        repeat (2) begin
            @(negedge clk);
            check_val("rst_busy", 32'(busy), 32'h7);
            check_val("rst_we", 32'(we), 32'd0);
            check_val("rst_data", 32'(wdata), 32'd0);
            check_val("rst_gid", 32'(gid), 32'd0);
        end

        // Round-robin order vs fixed-priority on identical stimulus.
        q_rr.push_back(mk(8'h10, 2'd0));
        q_rr.push_back(mk(8'h20, 2'd1));
        q_rr.push_back(mk(8'h30, 2'd2));
        q_rr.push_back(mk(8'h10, 2'd0));
        repeat (4) q_fix.push_back(mk(8'h30, 2'd2));
        mon_en = 1'b1;
        fix_en = 1'b1;
        rst    = 1'b0;
        @(negedge clk);
        check_val("first_grant_busy", 32'(busy), 32'h6);
        check_val("first_grant_gid", 32'(gid), 32'd0);
        check_val("fix_first_busy", 32'(fbusy), 32'h3);
        for (int i = 0; i < 40 && wr_cnt < 4; i++) begin
            @(negedge clk);
            #1;
        end
        check_val("rr_write_count", 32'(wr_cnt), 32'd4);
        req = 3'b000;
        repeat (3) @(negedge clk);
        check_val("rr_queue_empty", 32'(q_rr.size()), 32'd0);
        check_val("fix_queue_empty", 32'(q_fix.size()), 32'd0);
        fix_en = 1'b0;

        // Single request from writer 1.
        data[15:8] = 8'hA5;
        req        = 3'b010;
        q_rr.push_back(mk(8'hA5, 2'd1));
        @(negedge clk);
        check_val("single_busy", 32'(busy), 32'h5);
        check_val("single_gid", 32'(gid), 32'd1);
        check_val("single_we_early", 32'(we), 32'd0);
        @(negedge clk);
        check_val("single_we", 32'(we), 32'd1);
        req = 3'b000;
        @(negedge clk);
        check_val("single_idle_busy", 32'(busy), 32'h7);
        check_val("single_we_drop", 32'(we), 32'd0);

        // Backpressure: full blocks any grant until it drops.
        data[7:0] = 8'h5A;
        full      = 1'b1;
        req       = 3'b001;
        repeat (5) begin
            @(negedge clk);
            check_val("full_busy", 32'(busy), 32'h7);
            check_val("full_we", 32'(we), 32'd0);
        end
        full = 1'b0;
        q_rr.push_back(mk(8'h5A, 2'd0));
        @(negedge clk);
        check_val("unfull_busy", 32'(busy), 32'h6);
        @(negedge clk);
        check_val("unfull_we", 32'(we), 32'd1);
        req = 3'b000;
        @(negedge clk);
        check_val("bp_queue_empty", 32'(q_rr.size()), 32'd0);

        // Withdrawal: writer 2 granted then drops its request.
        data[23:16] = 8'hC3;
        req         = 3'b100;
        @(negedge clk);
        check_val("wd_busy", 32'(busy), 32'h3);
        check_val("wd_gid", 32'(gid), 32'd2);
        req = 3'b000;
        @(negedge clk);
        check_val("wd_release", 32'(busy), 32'h7);
        check_val("wd_no_we", 32'(we), 32'd0);
        @(negedge clk);
        check_val("wd_no_we2", 32'(we), 32'd0);
        req = 3'b111;
        q_rr.push_back(mk(8'h5A, 2'd0));
        @(negedge clk);
        check_val("wd_next_busy", 32'(busy), 32'h6);
        check_val("wd_next_gid", 32'(gid), 32'd0);
        @(negedge clk);
        check_val("wd_next_we", 32'(we), 32'd1);
        req = 3'b000;
        @(negedge clk);
        check_val("wd_queue_empty", 32'(q_rr.size()), 32'd0);

        // Reset while granted: no write, pointer back to 0.
        req = 3'b001;
        @(negedge clk);
        check_val("rg_busy", 32'(busy), 32'h6);
        rst = 1'b1;
        @(negedge clk);
        check_val("rg_rst_busy", 32'(busy), 32'h7);
        check_val("rg_rst_we", 32'(we), 32'd0);
        check_val("rg_rst_gid", 32'(gid), 32'd0);
        check_val("rg_rst_data", 32'(wdata), 32'd0);
        rst = 1'b0;
        req = 3'b111;
        q_rr.push_back(mk(8'h5A, 2'd0));
        @(negedge clk);
        check_val("rg_regrant_busy", 32'(busy), 32'h6);
        check_val("rg_regrant_gid", 32'(gid), 32'd0);
        @(negedge clk);
        check_val("rg_regrant_we", 32'(we), 32'd1);
        req = 3'b000;
        repeat (2) @(negedge clk);
        check_val("final_queue_empty", 32'(q_rr.size()), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
